// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand source
// selects and the stall FSM state type.
package hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_match.sv
// Per-operand comparator: chooses the EXE forward source for one operand and
// flags an ID-stage hazard for the matching ID operand.
module fwd_src_match
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              i_forward,
  input  logic [ADDR_W-1:0] i_exe_src,
  input  logic [ADDR_W-1:0] i_id_src,
  input  logic              i_id_vld,
  input  logic [ADDR_W-1:0] i_exe_dest,
  input  logic              i_exe_wb,
  input  logic              i_exe_mem_read,
  input  logic [ADDR_W-1:0] i_mem_dest,
  input  logic              i_mem_wb,
  input  logic [ADDR_W-1:0] i_wb_dest,
  input  logic              i_wb_wb,
  output logic [1:0]        o_sel,
  output logic              o_hz
);

  logic w_id_hit_exe;
  logic w_id_hit_mem;

  assign w_id_hit_exe = i_exe_wb && (i_id_src == i_exe_dest);
  assign w_id_hit_mem = i_mem_wb && (i_id_src == i_mem_dest);

  // With forwarding only a load in EXE is too late to bypass; WB is never a
  // hazard because the register file writes in the first half-cycle.
  assign o_hz = i_id_vld &&
                (i_forward ? (w_id_hit_exe && i_exe_mem_read)
                           : (w_id_hit_exe || w_id_hit_mem));

  always_comb begin
    o_sel = SEL_RF;
    if (i_forward) begin
      if (i_mem_wb && (i_exe_src == i_mem_dest)) begin
        o_sel = SEL_MEM;
      end else if (i_wb_wb && (i_exe_src == i_wb_dest)) begin
        o_sel = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: operand forward
// selects, load-use / RAW stall detection, multi-cycle stall FSM, freeze, flush.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter  int ADDR_W     = 4,
  parameter  int NUM_SRC    = 2,
  parameter  int LOAD_STALL = 1,
  localparam int CNT_W      = $clog2(LOAD_STALL + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      forward,
  input  logic                      mem_ready,
  input  logic                      flush,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic [NUM_SRC*ADDR_W-1:0] exe_src,
  input  logic [ADDR_W-1:0]         exe_dest,
  input  logic                      exe_wb,
  input  logic                      exe_mem_read,
  input  logic [ADDR_W-1:0]         mem_dest,
  input  logic                      mem_wb,
  input  logic [ADDR_W-1:0]         wb_dest,
  input  logic                      wb_wb,
  output logic [2*NUM_SRC-1:0]      sel_src,
  output logic                      stall,
  output logic                      bubble,
  output logic                      freeze,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      state_dbg
);

  localparam bit               MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2*NUM_SRC-1:0] w_sel;
  logic [NUM_SRC-1:0]   w_hz_op;
  logic                 w_hz;
  logic                 w_freeze;
  logic                 w_stall;
  logic                 w_bubble;
  hz_state_t            r_state;
  hz_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
    fwd_src_match #(
      .ADDR_W(ADDR_W)
    ) u_match (
      .i_forward      (forward),
      .i_exe_src      (exe_src[g*ADDR_W +: ADDR_W]),
      .i_id_src       (id_src[g*ADDR_W +: ADDR_W]),
      .i_id_vld       (id_src_vld[g]),
      .i_exe_dest     (exe_dest),
      .i_exe_wb       (exe_wb),
      .i_exe_mem_read (exe_mem_read),
      .i_mem_dest     (mem_dest),
      .i_mem_wb       (mem_wb),
      .i_wb_dest      (wb_dest),
      .i_wb_wb        (wb_wb),
      .o_sel          (w_sel[2*g +: 2]),
      .o_hz           (w_hz_op[g])
    );
  end

  assign w_hz     = |w_hz_op;
  assign w_freeze = ~mem_ready;

  // Freeze outranks flush, which outranks the FSM/hazard request.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    if (w_freeze) begin
      w_stall = 1'b1;
    end else if (flush) begin
      w_stall = 1'b0;
    end else if (r_state == STALL) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      w_stall  = w_hz;
      w_bubble = w_hz;
    end
  end

  // Flush clears the FSM even under back-pressure; otherwise nothing moves
  // while memory is not ready.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (mem_ready) begin
      case (r_state)
        IDLE: begin
          if (w_hz && forward && MULTI_STALL) begin
            w_state_nxt = STALL;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        STALL: begin
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // All outputs, including the purely combinational ones, read 0 during reset.
  assign sel_src   = rst_n ? w_sel : '0;
  assign stall     = rst_n & w_stall;
  assign bubble    = rst_n & w_bubble;
  assign freeze    = rst_n & w_freeze;
  assign stall_cnt = rst_n ? r_cnt : '0;
  assign state_dbg = rst_n & (r_state == STALL);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl (LOAD_STALL=3): table of combinational vectors
// plus hand-written multi-cycle stall, freeze, flush and reset sequences.
module tb_hazard_fwd_ctrl;

  localparam int ADDR_W     = 4;
  localparam int NUM_SRC    = 2;
  localparam int LOAD_STALL = 3;
  localparam int CNT_W      = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      forward;
  logic                      mem_ready;
  logic                      flush;
  logic [NUM_SRC*ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_vld;
  logic [NUM_SRC*ADDR_W-1:0] exe_src;
  logic [ADDR_W-1:0]         exe_dest;
  logic                      exe_wb;
  logic                      exe_mem_read;
  logic [ADDR_W-1:0]         mem_dest;
  logic                      mem_wb;
  logic [ADDR_W-1:0]         wb_dest;
  logic                      wb_wb;
  logic [2*NUM_SRC-1:0]      sel_src;
  logic                      stall;
  logic                      bubble;
  logic                      freeze;
  logic [CNT_W-1:0]          stall_cnt;
  logic                      state_dbg;

  hazard_fwd_ctrl #(
    .ADDR_W    (ADDR_W),
    .NUM_SRC   (NUM_SRC),
    .LOAD_STALL(LOAD_STALL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .forward     (forward),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .id_src      (id_src),
    .id_src_vld  (id_src_vld),
    .exe_src     (exe_src),
    .exe_dest    (exe_dest),
    .exe_wb      (exe_wb),
    .exe_mem_read(exe_mem_read),
    .mem_dest    (mem_dest),
    .mem_wb      (mem_wb),
    .wb_dest     (wb_dest),
    .wb_wb       (wb_wb),
    .sel_src     (sel_src),
    .stall       (stall),
    .bubble      (bubble),
    .freeze      (freeze),
    .stall_cnt   (stall_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       fwd;
    logic       mrdy;
    logic       fl;
    logic [7:0] ids;
    logic [1:0] vld;
    logic [7:0] exs;
    logic [3:0] exd;
    logic       exwb;
    logic       exld;
    logic [3:0] md;
    logic       mwb;
    logic [3:0] wd;
    logic       wwb;
    logic [3:0] e_sel;
    logic       e_stall;
    logic       e_bubble;
    logic       e_freeze;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic vec_t mk(string name, logic fwd, logic mrdy, logic fl,
                              logic [7:0] ids, logic [1:0] vld, logic [7:0] exs,
                              logic [3:0] exd, logic exwb, logic exld,
                              logic [3:0] md, logic mwb, logic [3:0] wd, logic wwb,
                              logic [3:0] e_sel, logic e_stall, logic e_bubble,
                              logic e_freeze);
    vec_t v;
    v.name = name; v.fwd = fwd; v.mrdy = mrdy; v.fl = fl;
    v.ids = ids; v.vld = vld; v.exs = exs; v.exd = exd;
    v.exwb = exwb; v.exld = exld; v.md = md; v.mwb = mwb;
    v.wd = wd; v.wwb = wwb; v.e_sel = e_sel;
    v.e_stall = e_stall; v.e_bubble = e_bubble; v.e_freeze = e_freeze;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_sel, input logic e_stall,
                         input logic e_bubble, input logic e_freeze,
                         input logic [1:0] e_cnt, input logic e_state);
    chk({tag, ".sel"},    32'(sel_src),   32'(e_sel));
    chk({tag, ".stall"},  32'(stall),     32'(e_stall));
    chk({tag, ".bubble"}, 32'(bubble),    32'(e_bubble));
    chk({tag, ".freeze"}, 32'(freeze),    32'(e_freeze));
    chk({tag, ".cnt"},    32'(stall_cnt), 32'(e_cnt));
    chk({tag, ".state"},  32'(state_dbg), 32'(e_state));
  endtask

  // driver tasks
  task automatic idle_in();
    forward = 1'b1; mem_ready = 1'b1; flush = 1'b0;
    id_src = '0; id_src_vld = '0; exe_src = '0; exe_dest = '0;
    exe_wb = 1'b0; exe_mem_read = 1'b0; mem_dest = '0; mem_wb = 1'b0;
    wb_dest = '0; wb_wb = 1'b0;
  endtask

  task automatic load_use();
    idle_in();
    exe_wb = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd5;
    id_src = 8'h05; id_src_vld = 2'b01;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input vec_t v);
    forward = v.fwd; mem_ready = v.mrdy; flush = v.fl;
    id_src = v.ids; id_src_vld = v.vld; exe_src = v.exs; exe_dest = v.exd;
    exe_wb = v.exwb; exe_mem_read = v.exld; mem_dest = v.md; mem_wb = v.mwb;
    wb_dest = v.wd; wb_wb = v.wwb;
  endtask

  initial begin
    int n_st;
    logic [6:0] e;

    // name fwd rdy fl ids vld exs exd exwb exld md mwb wd wwb | sel st bb fz
    vecs.push_back(mk("mem_prio",    1,1,0,8'h00,2'b00,8'h03,4'd0,0,0,4'd3,1,4'd3,1,4'b0001,0,0,0));
    vecs.push_back(mk("wb_only",     1,1,0,8'h00,2'b00,8'h03,4'd0,0,0,4'd3,0,4'd3,1,4'b0010,0,0,0));
    vecs.push_back(mk("src1_wb",     1,1,0,8'h00,2'b00,8'h53,4'd0,0,0,4'd5,0,4'd5,1,4'b1000,0,0,0));
    vecs.push_back(mk("split_src",   1,1,0,8'h00,2'b00,8'h96,4'd0,0,0,4'd9,1,4'd6,1,4'b0110,0,0,0));
    vecs.push_back(mk("fwd_off_sel", 0,1,0,8'h00,2'b00,8'h96,4'd0,0,0,4'd9,1,4'd6,1,4'b0000,0,0,0));
    vecs.push_back(mk("addr15",      1,1,0,8'h00,2'b00,8'hF0,4'd0,0,0,4'd15,1,4'd0,0,4'b0100,0,0,0));
    vecs.push_back(mk("load_use",    1,1,0,8'h05,2'b01,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,1,1,0));
    vecs.push_back(mk("lu_src1",     1,1,0,8'h50,2'b10,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,1,1,0));
    vecs.push_back(mk("lu_novld",    1,1,0,8'h05,2'b10,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,0,0,0));
    vecs.push_back(mk("alu_fwd",     1,1,0,8'h05,2'b01,8'h00,4'd5,1,0,4'd0,0,4'd0,0,4'b0000,0,0,0));
    vecs.push_back(mk("ld_nowb",     1,1,0,8'h05,2'b01,8'h00,4'd5,0,1,4'd0,0,4'd0,0,4'b0000,0,0,0));
    vecs.push_back(mk("raw_exe",     0,1,0,8'h50,2'b10,8'h00,4'd5,1,0,4'd0,0,4'd0,0,4'b0000,1,1,0));
    vecs.push_back(mk("raw_mem",     0,1,0,8'h70,2'b10,8'h77,4'd0,0,0,4'd7,1,4'd0,0,4'b0000,1,1,0));
    vecs.push_back(mk("raw_wb_no",   0,1,0,8'h77,2'b11,8'h00,4'd0,0,0,4'd0,0,4'd7,1,4'b0000,0,0,0));
    vecs.push_back(mk("raw_novld",   0,1,0,8'h77,2'b00,8'h00,4'd0,0,0,4'd7,1,4'd0,0,4'b0000,0,0,0));
    vecs.push_back(mk("frz_sel",     1,0,0,8'h00,2'b00,8'h03,4'd0,0,0,4'd3,1,4'd0,0,4'b0001,1,0,1));
    vecs.push_back(mk("frz_lu",      1,0,0,8'h05,2'b01,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,1,0,1));
    vecs.push_back(mk("frz_raw",     0,0,0,8'h70,2'b10,8'h00,4'd0,0,0,4'd7,1,4'd0,0,4'b0000,1,0,1));
    vecs.push_back(mk("flush_lu",    1,1,1,8'h05,2'b01,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,0,0,0));
    vecs.push_back(mk("flush_frz",   1,0,1,8'h05,2'b01,8'h00,4'd5,1,1,4'd0,0,4'd0,0,4'b0000,1,0,1));

    // reset: outputs forced low even with a hazard and a forward match present
    rst_n = 1'b0;
    load_use();
    mem_wb = 1'b1; mem_dest = 4'd0; mem_ready = 1'b0;
    #3;
    chk_all("reset", 4'b0000, 0, 0, 0, 2'd0, 0);
    idle_in();
    step();
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 4'b0000, 0, 0, 0, 2'd0, 0);

    // table: inputs are returned to idle before each edge so the FSM stays in IDLE
    foreach (vecs[k]) begin
      apply(vecs[k]);
      exp_q.push_back({vecs[k].e_sel, vecs[k].e_stall, vecs[k].e_bubble, vecs[k].e_freeze});
      #1;
      e = exp_q.pop_front();
      chk({"vec.", vecs[k].name}, 32'({sel_src, stall, bubble, freeze}), 32'(e));
      chk({"vec.", vecs[k].name, ".cnt"}, 32'({state_dbg, stall_cnt}), 32'd0);
      idle_in();
      step();
    end

    // load-use: three stall cycles, stall_cnt 0,2,1 then 0
    load_use();
    #1; chk_all("lu.c0", 4'b0000, 1, 1, 0, 2'd0, 0);
    step(); idle_in();
    #1; chk_all("lu.c1", 4'b0000, 1, 1, 0, 2'd2, 1);
    step();
    #1; chk_all("lu.c2", 4'b0000, 1, 1, 0, 2'd1, 1);
    step();
    #1; chk_all("lu.c3", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // back-pressure mid-stall: count held, five stall cycles in total
    n_st = 0;
    load_use();
    #1; n_st += int'(stall);
    step(); idle_in();
    #1; n_st += int'(stall); chk_all("bp.c1", 4'b0000, 1, 1, 0, 2'd2, 1);
    step(); mem_ready = 1'b0;
    #1; n_st += int'(stall); chk_all("bp.c2", 4'b0000, 1, 0, 1, 2'd1, 1);
    step();
    #1; n_st += int'(stall); chk_all("bp.c3", 4'b0000, 1, 0, 1, 2'd1, 1);
    step(); mem_ready = 1'b1;
    #1; n_st += int'(stall); chk_all("bp.c4", 4'b0000, 1, 1, 0, 2'd1, 1);
    step();
    #1; n_st += int'(stall); chk_all("bp.c5", 4'b0000, 0, 0, 0, 2'd0, 0);
    chk("bp.stall_total", 32'(n_st), 32'd5);
    step();

    // forward=0 RAW: stall follows the hazard each cycle, FSM never leaves IDLE
    idle_in(); forward = 1'b0; id_src = 8'h70; id_src_vld = 2'b10;
    mem_wb = 1'b1; mem_dest = 4'd7; exe_src = 8'h77;
    for (int c = 0; c < 3; c++) begin
      #1; chk_all("raw_hold", 4'b0000, 1, 1, 0, 2'd0, 0);
      step();
    end
    idle_in();
    #1; chk_all("raw_clear", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // forward toggled off during STALL does not abort the count
    load_use();
    step(); idle_in(); forward = 1'b0;
    #1; chk_all("tog.c1", 4'b0000, 1, 1, 0, 2'd2, 1);
    step();
    #1; chk_all("tog.c2", 4'b0000, 1, 1, 0, 2'd1, 1);
    step(); forward = 1'b1;
    #1; chk_all("tog.c3", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // flush during STALL (cnt=2)
    load_use();
    step(); idle_in(); flush = 1'b1;
    #1; chk_all("flush.c1", 4'b0000, 0, 0, 0, 2'd2, 1);
    step(); flush = 1'b0;
    #1; chk_all("flush.c2", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // flush during STALL under back-pressure: freeze wins this cycle, FSM still clears
    load_use();
    step(); idle_in(); flush = 1'b1; mem_ready = 1'b0;
    #1; chk_all("flfrz.c1", 4'b0000, 1, 0, 1, 2'd2, 1);
    step(); flush = 1'b0; mem_ready = 1'b1;
    #1; chk_all("flfrz.c2", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // asynchronous reset mid-STALL with memory back-pressure
    load_use();
    step(); idle_in(); mem_ready = 1'b0;
    exe_src = 8'h33; mem_wb = 1'b1; mem_dest = 4'd3;
    #1; chk_all("rst.pre", 4'b0101, 1, 0, 1, 2'd2, 1);
    rst_n = 1'b0;
    #1; chk_all("rst.low", 4'b0000, 0, 0, 0, 2'd0, 0);
    rst_n = 1'b1; idle_in();
    step();
    #1; chk_all("rst.after", 4'b0000, 0, 0, 0, 2'd0, 0);
    step();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
